// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch/sequencing unit: opcode map, FSM state
// encoding, fault codes and small opcode-classification helpers.
package fetch_sequencer_pkg;

  // Opcode map (instr[15:12])
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SHL  = 4'h5;
  localparam logic [3:0] OP_SHR  = 4'h6;
  localparam logic [3:0] OP_SLT  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_LUI  = 4'h9;
  localparam logic [3:0] OP_LDW  = 4'hA;
  localparam logic [3:0] OP_STW  = 4'hB;
  localparam logic [3:0] OP_BRZ  = 4'hC;
  localparam logic [3:0] OP_JAL  = 4'hD;
  localparam logic [3:0] OP_ILL0 = 4'hE;
  localparam logic [3:0] OP_ILL1 = 4'hF;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FAULT_NONE    = 2'b00,
    FAULT_ILLEGAL = 2'b01,
    FAULT_TIMEOUT = 2'b10
  } fault_t;

  function automatic logic is_illegal(input logic [3:0] op);
    return (op == OP_ILL0) || (op == OP_ILL1);
  endfunction

  // Memory ops hold EXEC until the data memory reports completion.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LDW) || (op == OP_STW);
  endfunction

endpackage

// File: rtl/fetch_sequencer_pc_next.sv
// Combinational next-PC selector.
// Ports:
//   pc, instr          current instruction address and word
//   jump, branch, zero control-unit decode and ALU zero flag
//   next_pc            PC after this instruction (jump > taken branch > pc+1)
//   link_addr          pc+1, for JAL's link register write
module fetch_sequencer_pc_next
  import fetch_sequencer_pkg::*;
(
  input  logic [15:0] pc,
  input  logic [15:0] instr,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  output logic [15:0] next_pc,
  output logic [15:0] link_addr
);

  logic [15:0] seq_pc;
  logic [15:0] br_off;
  logic [15:0] jal_tgt;
  logic        unused_rs;

  // rs field is not an address component
  assign unused_rs = ^instr[7:4];

  assign seq_pc  = pc + 16'd1;
  // BRZ offset is split around the rs field: {rd, rt}, sign-extended
  assign br_off  = {{8{instr[11]}}, instr[11:8], instr[3:0]};
  assign jal_tgt = {pc[15:12], instr[11:0]};

  always_comb begin
    next_pc = seq_pc;
    if (jump)
      next_pc = jal_tgt;
    else if (branch && zero)
      next_pc = seq_pc + br_off;
  end

  assign link_addr = seq_pc;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch/sequencing unit. Fetches 16-bit words over an imem
// req/ack handshake, holds the instruction for execute, gates datapath
// writes with exec_en and advances the PC from jump/branch/zero.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   imem_req/addr/ack/rdata   instruction memory handshake
//   opcode, instr             latched instruction to control/datapath
//   exec_en                   instruction in execute
//   jump, branch, zero        next-PC controls (from control unit / ALU)
//   dmem_done                 LDW/STW data access complete
//   pc, link_addr             current PC and pc+1
//   halted, fault             sticky halt and its cause
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR  = 16'h0000,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [3:0]  opcode,
  output logic [15:0] instr,
  output logic        exec_en,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  input  logic        dmem_done,
  output logic [15:0] pc,
  output logic [15:0] link_addr,
  output logic        halted,
  output logic [1:0]  fault
);

  localparam int              CW       = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(FETCH_TIMEOUT - 1);

  state_t        state, state_nxt;
  fault_t        fault_q;
  logic [15:0]   pc_q;
  logic [15:0]   instr_q;
  logic [15:0]   next_pc;
  logic [CW-1:0] cnt;
  // Two-stage startup so imem_req stays low for the first cycle out of reset
  logic [1:0]    boot;
  logic          fetching;
  logic          ack_v;
  logic          exec_done;

  fetch_sequencer_pc_next u_pc_next (
    .pc        (pc_q),
    .instr     (instr_q),
    .jump      (jump),
    .branch    (branch),
    .zero      (zero),
    .next_pc   (next_pc),
    .link_addr (link_addr)
  );

  // Acks are only meaningful while a request is outstanding
  assign ack_v     = imem_ack && fetching;
  assign exec_done = (state == S_EXEC) && (!is_mem_op(instr_q[15:12]) || dmem_done);

  always_comb begin
    state_nxt = state;
    fetching  = 1'b0;
    exec_en   = 1'b0;
    halted    = 1'b0;
    unique case (state)
      S_FETCH: begin
        fetching = boot[1];
        // An ack on the final counted cycle beats the timeout
        if (imem_ack && boot[1])
          state_nxt = is_illegal(imem_rdata[15:12]) ? S_HALT : S_EXEC;
        else if (boot[1] && cnt == CNT_LAST)
          state_nxt = S_HALT;
      end
      S_EXEC: begin
        exec_en = 1'b1;
        if (exec_done) state_nxt = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      pc_q    <= RESET_VECTOR;
      instr_q <= 16'h0000;
      fault_q <= FAULT_NONE;
      cnt     <= '0;
      boot    <= 2'b00;
    end else begin
      state <= state_nxt;
      boot  <= {boot[0], 1'b1};
      if (ack_v) begin
        instr_q <= imem_rdata;
        cnt     <= '0;
      end else if (fetching) begin
        cnt <= cnt + CW'(1);
      end
      if (state == S_FETCH && state_nxt == S_HALT)
        fault_q <= ack_v ? FAULT_ILLEGAL : FAULT_TIMEOUT;
      if (exec_done)
        pc_q <= next_pc;
    end
  end

  assign imem_req  = fetching;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign opcode    = instr_q[15:12];
  assign fault     = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table, randomized
// instruction stream against a PC reference model, and fault/reset sequences.
module tb_fetch_sequencer;

  localparam logic [15:0] RV = 16'h0040;
  localparam int          TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [3:0]  opcode;
  logic [15:0] instr;
  logic        exec_en;
  logic        jump, branch, zero, dmem_done;
  logic [15:0] pc;
  logic [15:0] link_addr;
  logic        halted;
  logic [1:0]  fault;

  int n_chk  = 0;
  int n_fail = 0;
  logic [15:0] mpc;

  fetch_sequencer #(.RESET_VECTOR(RV), .FETCH_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .opcode(opcode),
    .instr(instr), .exec_en(exec_en), .jump(jump), .branch(branch),
    .zero(zero), .dmem_done(dmem_done), .pc(pc), .link_addr(link_addr),
    .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] rd;
    int          lat;
    logic        j, b, z;
    int          dw;
    logic [15:0] nxt;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Next PC straight from the ISA rules, in plain integer arithmetic
  function automatic logic [15:0] model_next(input logic [15:0] p, input logic [15:0] rd,
                                             input logic j, input logic b, input logic z);
    int off;
    off = int'(rd[11:8]) * 16 + int'(rd[3:0]);
    if (off >= 128) off = off - 256;
    if (j) return {p[15:12], rd[11:0]};
    if (b && z) return 16'((int'(p) + 1 + off) & 32'hFFFF);
    return 16'((int'(p) + 1) & 32'hFFFF);
  endfunction

  task automatic do_reset();
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 16'h0000;
    jump = 1'b0; branch = 1'b0; zero = 1'b0; dmem_done = 1'b0;
    tick(); tick();
    chk("rst_pc", pc, RV);
    chk("rst_addr", imem_addr, RV);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_req", 16'(imem_req), 16'h0);
    chk("rst_exec", 16'(exec_en), 16'h0);
    chk("rst_halted", 16'(halted), 16'h0);
    chk("rst_fault", 16'(fault), 16'h0);
    // stray ack while imem_req is low must be ignored
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 16'hE000;
    tick();
    chk("boot_req_low", 16'(imem_req), 16'h0);
    imem_ack = 1'b0;
    tick();
    chk("boot_req_high", 16'(imem_req), 16'h1);
    chk("boot_ack_ignored", 16'(halted), 16'h0);
    mpc = RV;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!imem_req && n < 40) begin tick(); n++; end
    chk("req_seen", 16'(imem_req), 16'h1);
  endtask

  task automatic run_instr(input logic [15:0] rd, input int lat, input logic j,
                           input logic b, input logic z, input int dw,
                           input logic [15:0] nxt);
    wait_req();
    chk("fetch_addr", imem_addr, mpc);
    for (int k = 0; k < lat; k++) begin
      chk("req_hold", 16'(imem_req), 16'h1);
      tick();
    end
    imem_ack = 1'b1; imem_rdata = rd;
    tick();
    imem_ack = 1'b0; imem_rdata = 16'($urandom);
    chk("exec_en", 16'(exec_en), 16'h1);
    chk("req_drop", 16'(imem_req), 16'h0);
    chk("opcode", 16'(opcode), 16'(rd[15:12]));
    chk("instr", instr, rd);
    chk("link_addr", link_addr, mpc + 16'd1);
    jump = j; branch = b; zero = z;
    if (rd[15:12] == 4'hA || rd[15:12] == 4'hB) begin
      for (int k = 0; k < dw; k++) begin
        dmem_done = 1'b0;
        if (k == 0) begin imem_ack = 1'b1; imem_rdata = 16'hF000; end
        tick();
        imem_ack = 1'b0;
        chk("mem_wait_exec", 16'(exec_en), 16'h1);
        chk("mem_wait_instr", instr, rd);
        chk("mem_wait_pc", pc, mpc);
      end
      dmem_done = 1'b1;
    end else begin
      dmem_done = 1'b0;
    end
    tick();
    jump = 1'b0; branch = 1'b0; zero = 1'b0; dmem_done = 1'b0;
    chk("exec_done", 16'(exec_en), 16'h0);
    chk("next_pc", pc, nxt);
    chk("refetch_req", 16'(imem_req), 16'h1);
    mpc = nxt;
  endtask

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{16'h0123, 1,  1'b0, 1'b0, 1'b0, 0, 16'h0041}; // ADD
    tbl[1]  = '{16'hD010, 1,  1'b1, 1'b0, 1'b0, 0, 16'h0010}; // JAL
    tbl[2]  = '{16'hCF5E, 0,  1'b0, 1'b1, 1'b1, 0, 16'h000F}; // BRZ taken, -2
    tbl[3]  = '{16'hD010, 2,  1'b1, 1'b0, 1'b0, 0, 16'h0010};
    tbl[4]  = '{16'hCF5E, 1,  1'b0, 1'b1, 1'b0, 0, 16'h0011}; // BRZ not taken
    tbl[5]  = '{16'hA120, 1,  1'b0, 1'b0, 1'b0, 3, 16'h0012}; // LDW, 3 wait cycles
    tbl[6]  = '{16'hB000, 15, 1'b0, 1'b0, 1'b0, 0, 16'h0013}; // ack on last timeout cycle
    tbl[7]  = '{16'hD040, 1,  1'b1, 1'b0, 1'b0, 0, 16'h0040};
    tbl[8]  = '{16'hCB0E, 1,  1'b0, 1'b1, 1'b1, 0, 16'hFFFF}; // BRZ -66 wraps below 0
    tbl[9]  = '{16'h0123, 1,  1'b0, 1'b0, 1'b0, 0, 16'h0000}; // sequential wrap
    tbl[10] = '{16'hDFFF, 1,  1'b1, 1'b0, 1'b0, 0, 16'h0FFF};
    tbl[11] = '{16'hC70F, 1,  1'b0, 1'b1, 1'b1, 0, 16'h107F}; // BRZ +127
    tbl[12] = '{16'hD234, 1,  1'b1, 1'b0, 1'b0, 0, 16'h1234};
    tbl[13] = '{16'hD0AB, 1,  1'b1, 1'b0, 1'b0, 0, 16'h10AB}; // JAL from 1234
    tbl[14] = '{16'hD0AB, 1,  1'b1, 1'b1, 1'b1, 0, 16'h10AB}; // jump beats branch

    @(negedge clk);
    do_reset();

    foreach (tbl[i])
      run_instr(tbl[i].rd, tbl[i].lat, tbl[i].j, tbl[i].b, tbl[i].z, tbl[i].dw, tbl[i].nxt);

    // Randomized legal instruction stream against the reference model
    for (int i = 0; i < 150; i++) begin
      logic [3:0]  op;
      logic [15:0] rd;
      logic        z;
      int          lat;
      op  = 4'($urandom_range(0, 13));
      rd  = {op, 12'($urandom)};
      z   = 1'($urandom);
      lat = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO - 1) : $urandom_range(0, 1);
      run_instr(rd, lat, op == 4'hD, op == 4'hC, z, $urandom_range(0, 3),
                model_next(mpc, rd, op == 4'hD, op == 4'hC, z));
    end

    // Illegal opcode: halt with fault 01, never execute, sticky
    wait_req();
    imem_ack = 1'b1; imem_rdata = 16'hE000;
    tick();
    imem_ack = 1'b0;
    chk("ill_halted", 16'(halted), 16'h1);
    chk("ill_fault", 16'(fault), 16'h1);
    chk("ill_exec", 16'(exec_en), 16'h0);
    chk("ill_pc", pc, mpc);
    for (int k = 0; k < 4; k++) begin
      imem_ack = 1'b1; imem_rdata = 16'h0000;
      tick();
      chk("ill_sticky", {halted, imem_req, exec_en, fault}, {1'b1, 1'b0, 1'b0, 2'b01});
      chk("ill_pc_hold", pc, mpc);
    end
    imem_ack = 1'b0;

    // Fetch timeout: FETCH_TIMEOUT unacked request cycles then halt
    do_reset();
    for (int k = 0; k < TO; k++) begin
      chk("to_req", {imem_req, halted}, 16'b10);
      tick();
    end
    chk("to_halted", 16'(halted), 16'h1);
    chk("to_fault", 16'(fault), 16'h2);
    chk("to_req_off", 16'(imem_req), 16'h0);
    chk("to_pc", pc, RV);

    // Reset mid-fetch: restart at RESET_VECTOR with a fresh timeout count
    do_reset();
    run_instr(16'h0555, 1, 1'b0, 1'b0, 1'b0, 0, RV + 16'd1);
    wait_req();
    for (int k = 0; k < 10; k++) tick();
    do_reset();
    run_instr(16'h1234, TO - 1, 1'b0, 1'b0, 1'b0, 0, RV + 16'd1);
    chk("post_rst_fault", 16'(fault), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
